// File: rtl/sol_claim_arbiter.sv
// Round-robin arbiter sharing one host solution channel between NUM_CORES SHA cores; claim in RUN -> sol_claim next cycle.
// Cores hold level claims until acked; the host stalls presentation up to TIMEOUT_CYCLES, then the grant is retired as a reject.
module sol_claim_arbiter #(
  parameter int NUM_CORES      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start_found,
  input  logic [NUM_CORES-1:0]    core_claim,
  input  logic [32*NUM_CORES-1:0] core_nonce,
  output logic [NUM_CORES-1:0]    core_ack,
  output logic                    core_abort,
  output logic                    sol_claim,
  output logic [31:0]             out_data,
  input  logic [1:0]              sol_response,
  output logic [7:0]              found_count,
  output logic                    timeout_err
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PRESENT = 3'd2,
    RETIRE  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t         state;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  grant;
  logic [TW-1:0]  timer;

  logic           pick_vld;
  logic [IW-1:0]  pick_idx;
  logic [IW:0]    scan_idx;
  logic [IW-1:0]  next_ptr;
  logic           accept;
  logic           reject;
  logic           timed_out;

  // Scan from the farthest offset down so the nearest claim at/after rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr} + (IW+1)'(k);
      if (scan_idx >= (IW+1)'(NUM_CORES)) begin
        scan_idx = scan_idx - (IW+1)'(NUM_CORES);
      end
      if (core_claim[scan_idx[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx[IW-1:0];
      end
    end
  end

  always_comb begin
    next_ptr  = (grant == IW'(NUM_CORES - 1)) ? '0 : grant + 1'b1;
    accept    = (sol_response == 2'b01);
    timed_out = (sol_response == 2'b00) && (timer == TW'(TIMEOUT_CYCLES - 1));
    reject    = sol_response[1] || timed_out;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      timer       <= '0;
      sol_claim   <= 1'b0;
      out_data    <= '0;
      core_ack    <= '0;
      core_abort  <= 1'b0;
      found_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      core_ack    <= '0;
      core_abort  <= 1'b0;
      timeout_err <= 1'b0;
      // A new job rearms the arbiter and overrides any response landing this cycle.
      if (start_found) begin
        state     <= RUN;
        sol_claim <= 1'b0;
        rr_ptr    <= '0;
        timer     <= '0;
      end else begin
        case (state)
          RUN: begin
            if (pick_vld) begin
              grant     <= pick_idx;
              out_data  <= core_nonce[32*pick_idx +: 32];
              timer     <= '0;
              sol_claim <= 1'b1;
              state     <= PRESENT;
            end
          end
          PRESENT: begin
            if (accept) begin
              core_ack   <= NUM_CORES'(1) << grant;
              core_abort <= 1'b1;
              if (found_count != 8'hFF) begin
                found_count <= found_count + 8'd1;
              end
              sol_claim  <= 1'b0;
              state      <= DONE;
            end else if (reject) begin
              core_ack    <= NUM_CORES'(1) << grant;
              timeout_err <= timed_out;
              rr_ptr      <= next_ptr;
              sol_claim   <= 1'b0;
              state       <= RETIRE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          // Dead cycle lets the acked core drop its claim before the next scan.
          RETIRE: state <= RUN;
          IDLE, DONE: state <= state;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sol_claim_arbiter.sv
// Directed bench for sol_claim_arbiter with a transaction-level reference model checked every cycle.
module tb_sol_claim_arbiter;
  localparam int N = 4;
  localparam int T = 16;

  logic           clk = 1'b0;
  logic           n_rst;
  logic           start_found;
  logic [N-1:0]   core_claim;
  logic [32*N-1:0] core_nonce;
  logic [N-1:0]   core_ack;
  logic           core_abort;
  logic           sol_claim;
  logic [31:0]    out_data;
  logic [1:0]     sol_response;
  logic [7:0]     found_count;
  logic           timeout_err;

  sol_claim_arbiter #(.NUM_CORES(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .n_rst(n_rst), .start_found(start_found),
    .core_claim(core_claim), .core_nonce(core_nonce),
    .core_ack(core_ack), .core_abort(core_abort),
    .sol_claim(sol_claim), .out_data(out_data),
    .sol_response(sol_response), .found_count(found_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: armed = job running and not yet solved; pres = a nonce is on the host channel.
  bit          m_armed, m_pres, m_gap, m_abort, m_to;
  int          m_grant, m_ptr, m_age, m_found;
  logic [31:0] m_data;
  logic [N-1:0] m_ack;

  always @(posedge clk) begin
    m_ack   = '0;
    m_abort = 1'b0;
    m_to    = 1'b0;
    if (!n_rst) begin
      m_armed = 0; m_pres = 0; m_gap = 0;
      m_ptr = 0; m_age = 0; m_found = 0; m_grant = 0;
      m_data = '0;
    end else if (start_found) begin
      m_armed = 1; m_pres = 0; m_gap = 0; m_ptr = 0;
    end else if (m_pres) begin
      if (sol_response == 2'b01) begin
        m_ack[m_grant] = 1'b1;
        m_abort = 1'b1;
        if (m_found < 255) m_found++;
        m_pres = 0;
        m_armed = 0;
      end else if (sol_response >= 2'b10 || m_age == T - 1) begin
        m_ack[m_grant] = 1'b1;
        m_to  = (sol_response == 2'b00);
        m_ptr = (m_grant + 1) % N;
        m_pres = 0;
        m_gap = 1;
      end else begin
        m_age++;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (m_armed) begin
      for (int k = 0; k < N; k++) begin
        if (!m_pres && core_claim[(m_ptr + k) % N]) begin
          m_grant = (m_ptr + k) % N;
          m_data  = core_nonce[32*m_grant +: 32];
          m_pres  = 1;
          m_age   = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_sol_claim", sol_claim, m_pres);
      chk("cyc_out_data", out_data, m_data);
      chk("cyc_core_ack", core_ack, m_ack);
      chk("cyc_core_abort", core_abort, m_abort);
      chk("cyc_found_count", found_count, m_found);
      chk("cyc_timeout_err", timeout_err, m_to);
    end
  end

  task automatic wait_present(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (sol_claim === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    chk(name, ok, 1);
  endtask

  task automatic respond(input logic [1:0] r);
    sol_response = r;
    @(negedge clk);
    sol_response = 2'b00;
  endtask

  task automatic pulse_start();
    start_found = 1'b1;
    @(negedge clk);
    start_found = 1'b0;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};
  int cnt;

  initial begin
    n_rst = 1'b0; start_found = 1'b0; core_claim = '0; core_nonce = '0; sol_response = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_sol_claim", sol_claim, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_found", found_count, 0);
    n_rst = 1'b1;
    @(negedge clk);

    // 1: single claim on core 2, one-cycle latency, nonce frozen at grant
    core_claim = 4'b0100;
    @(negedge clk);
    chk("t1_idle_ignores", sol_claim, 0);
    pulse_start();
    core_nonce[64 +: 32] = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_sol_claim", sol_claim, 1);
    chk("t1_out_data", out_data, 32'hDEADBEEF);
    core_nonce[64 +: 32] = 32'h12345678;
    @(negedge clk);
    chk("t1_hold", out_data, 32'hDEADBEEF);
    respond(2'b10);
    chk("t1_ack", core_ack, 4'b0100);
    core_claim = '0;
    @(negedge clk);
    @(negedge clk);

    // 2: all cores claiming, rejects walk the round-robin pointer
    pulse_start();
    for (int i = 0; i < N; i++) core_nonce[32*i +: 32] = 32'hA000_0000 + i;
    core_claim = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_present("t2_wait");
      chk("t2_grant", out_data, 32'hA000_0000 + exp_order[n]);
      respond(2'b11 - 2'(n % 2));
      chk("t2_ack", core_ack, 4'b0001 << exp_order[n]);
      @(negedge clk);
      chk("t2_ack_pulse", core_ack, 0);
      chk("t2_retire_gap", sol_claim, 0);
    end
    core_claim = '0;
    @(negedge clk);

    // 3: accept aborts everyone and DONE ignores new claims
    pulse_start();
    core_claim = 4'b0010;
    wait_present("t3_wait");
    chk("t3_grant", out_data, 32'hA000_0001);
    respond(2'b01);
    chk("t3_ack", core_ack, 4'b0010);
    chk("t3_abort", core_abort, 1);
    chk("t3_found", found_count, 1);
    core_claim = 4'b1000;
    repeat (6) @(negedge clk);
    chk("t3_done_ignores", sol_claim, 0);
    core_claim = '0;

    // 4: host silence times out after T presentation cycles
    pulse_start();
    core_claim = 4'b0011;
    wait_present("t4_wait");
    chk("t4_grant", out_data, 32'hA000_0000);
    cnt = 0;
    while (sol_claim === 1'b1 && cnt < T + 8) begin
      cnt++;
      @(negedge clk);
    end
    chk("t4_present_len", cnt, T);
    chk("t4_timeout", timeout_err, 1);
    chk("t4_ack", core_ack, 4'b0001);
    core_claim = 4'b0010;
    @(negedge clk);
    chk("t4_timeout_pulse", timeout_err, 0);
    wait_present("t4_wait2");
    chk("t4_next_grant", out_data, 32'hA000_0001);

    // 5: start_found beats an accept in the same cycle
    sol_response = 2'b01;
    start_found  = 1'b1;
    @(negedge clk);
    sol_response = 2'b00;
    start_found  = 1'b0;
    chk("t5_no_ack", core_ack, 0);
    chk("t5_no_abort", core_abort, 0);
    chk("t5_found", found_count, 1);
    chk("t5_sol_claim", sol_claim, 0);
    @(negedge clk);
    chk("t5_run_regrant", sol_claim, 1);
    respond(2'b10);
    core_claim = '0;
    @(negedge clk);

    // 6: found_count saturates, then reset mid-presentation
    for (int n = 0; n < 256; n++) begin
      pulse_start();
      core_claim = 4'b0001;
      wait_present("t6_wait");
      respond(2'b01);
      core_claim = '0;
    end
    chk("t6_saturate", found_count, 255);
    pulse_start();
    core_claim = 4'b0001;
    wait_present("t6_wait_rst");
    n_rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_sol_claim", sol_claim, 0);
    chk("t6_rst_out_data", out_data, 0);
    chk("t6_rst_ack", core_ack, 0);
    chk("t6_rst_abort", core_abort, 0);
    chk("t6_rst_found", found_count, 0);
    chk("t6_rst_timeout", timeout_err, 0);
    n_rst = 1'b1;
    core_claim = '0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
